// File: rtl/ws_requant_scheduler_pkg.sv
// ws_pkg: shared sizing, state encoding, result record and saturation helper
// for the weight-stationary requantisation scheduler.
//   SA_COL/PSUM_WIDTH   shape of one incoming psum vector
//   DATA_WIDTH          signed output activation width
//   NUM_OC/NUM_PIX      pass geometry (channel is the inner loop)
//   SHIFT               arithmetic right shift applied to the reduced sum
//   FIFO_DEPTH          output queue depth (power of 2, >= 2)
package ws_pkg;
   localparam int SA_COL     = 3;
   localparam int PSUM_WIDTH = 19;
   localparam int DATA_WIDTH = 8;
   localparam int NUM_OC     = 4;
   localparam int NUM_PIX    = 16;
   localparam int SHIFT      = 7;
   localparam int FIFO_DEPTH = 4;

   localparam int OC_W  = $clog2(NUM_OC);
   localparam int PIX_W = $clog2(NUM_PIX);
   // One guard bit beyond the column-growth bits keeps the reduced sum exact.
   localparam int SUM_W = PSUM_WIDTH + $clog2(SA_COL) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } req_state_t;

   typedef struct packed {
      logic signed [DATA_WIDTH-1:0] data;
      logic [OC_W-1:0]              oc;
      logic [PIX_W-1:0]             pix;
   } res_t;

   localparam logic signed [SUM_W:0] SAT_HI = (SUM_W+1)'(2**(DATA_WIDTH-1)-1);
   localparam logic signed [SUM_W:0] SAT_LO = ~SAT_HI;

   // Clamp a biased, shifted sum into the signed output range.
   function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [SUM_W:0] v);
      logic signed [DATA_WIDTH-1:0] r;
      if (v > SAT_HI)      r = SAT_HI[DATA_WIDTH-1:0];
      else if (v < SAT_LO) r = SAT_LO[DATA_WIDTH-1:0];
      else                 r = v[DATA_WIDTH-1:0];
      return r;
   endfunction
endpackage

// File: rtl/ws_requant_scheduler_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count.
//   clk/rst     clock, synchronous active-high reset (clears storage too)
//   push/din    write strobe and data
//   pop/dout    read strobe; dout shows the head entry combinationally
//   empty/full  occupancy flags, count = entries held
// A push and pop in the same cycle are both performed, also when full.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        wr, rd;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   assign rd = pop & ~empty;
   assign wr = push & (~full | rd);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(wr) - CW'(rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/ws_requant_scheduler.sv
// ws_requant_scheduler: sequences requantisation of systolic-array column psums.
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin a pass (IDLE only)
//   cfg_we/cfg_addr/cfg_bias per-channel bias table write (IDLE only)
//   psum_valid/psum_ready    psum vector handshake, psum_i packed per column
//   out_valid/out_ready      result handshake, out_data with out_oc/out_pix tags
//   busy                     any state other than IDLE
//   done                     one-cycle pulse when a pass has fully drained
// Datapath: S1 reduces the columns, S2 shifts, adds bias[oc], saturates and
// pushes into the output FIFO. Input ready is credit based so the FIFO can
// always absorb every vector already in the two pipeline stages.
module ws_requant_scheduler
   import ws_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start,
   input  logic                                 cfg_we,
   input  logic [OC_W-1:0]                      cfg_addr,
   input  logic [DATA_WIDTH-1:0]                cfg_bias,
   input  logic                                 psum_valid,
   output logic                                 psum_ready,
   input  logic [SA_COL-1:0][PSUM_WIDTH-1:0]    psum_i,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [DATA_WIDTH-1:0]                out_data,
   output logic [OC_W-1:0]                      out_oc,
   output logic [PIX_W-1:0]                     out_pix,
   output logic                                 busy,
   output logic                                 done
);
   localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
   localparam int CR_W = FCW + 1;

   req_state_t                        state_q, state_d;
   logic [OC_W-1:0]                   oc_cnt_q, oc_cnt_d;
   logic [PIX_W-1:0]                  pix_cnt_q, pix_cnt_d;
   logic [NUM_OC-1:0][DATA_WIDTH-1:0] bias_q, bias_d;

   logic [2:1]                        vld_pipe_q, vld_pipe_d;
   logic signed [SUM_W-1:0]           s1_sum_q, s1_sum_d;
   logic [OC_W-1:0]                   s1_oc_q, s1_oc_d;
   logic [PIX_W-1:0]                  s1_pix_q, s1_pix_d;
   res_t                              s2_q, s2_d;

   logic [SA_COL-1:0][SUM_W-1:0]      psum_ext;
   logic signed [SUM_W:0]             sum_ext, bias_ext, biased;
   logic [DATA_WIDTH-1:0]             bias_sel;

   res_t                              fifo_dout;
   logic                              fifo_empty, fifo_full, fifo_pop;
   logic [FCW-1:0]                    fifo_count;
   logic [CR_W-1:0]                   credit_used;
   logic                              accept, last_vec;

   // Credits: queued results plus vectors still in S1/S2.
   assign credit_used = CR_W'(fifo_count) + CR_W'(vld_pipe_q[1]) + CR_W'(vld_pipe_q[2]);
   assign psum_ready  = (state_q == RUN) && (credit_used < CR_W'(FIFO_DEPTH));
   assign accept      = psum_valid & psum_ready;
   assign last_vec    = (oc_cnt_q == OC_W'(NUM_OC-1)) && (pix_cnt_q == PIX_W'(NUM_PIX-1));

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign out_valid = ~fifo_empty;
   assign out_data  = fifo_dout.data;
   assign out_oc    = fifo_dout.oc;
   assign out_pix   = fifo_dout.pix;
   assign fifo_pop  = out_valid & out_ready;

   // Sign-extend each column to the reduction width.
   genvar g;
   generate
      for (g = 0; g < SA_COL; g++) begin : g_ext
         assign psum_ext[g] = {{(SUM_W-PSUM_WIDTH){psum_i[g][PSUM_WIDTH-1]}}, psum_i[g]};
      end
   endgenerate

   // S1: column reduction, tagged with the current channel/pixel counters.
   always_comb begin
      s1_sum_d = '0;
      for (int i = 0; i < SA_COL; i++) s1_sum_d = s1_sum_d + psum_ext[i];
      s1_oc_d  = oc_cnt_q;
      s1_pix_d = pix_cnt_q;
   end

   // S2: floor shift, bias add, saturate. All operands are signed at SUM_W+1
   // so >>> stays arithmetic.
   always_comb begin
      bias_sel    = bias_q[s1_oc_q];
      sum_ext     = {s1_sum_q[SUM_W-1], s1_sum_q};
      bias_ext    = {{(SUM_W+1-DATA_WIDTH){bias_sel[DATA_WIDTH-1]}}, bias_sel};
      biased      = (sum_ext >>> SHIFT) + bias_ext;
      s2_d.data   = sat_dw(biased);
      s2_d.oc     = s1_oc_q;
      s2_d.pix    = s1_pix_q;
      vld_pipe_d  = {vld_pipe_q[1], accept};
   end

   // FSM, pass counters and bias table.
   always_comb begin
      state_d   = state_q;
      oc_cnt_d  = oc_cnt_q;
      pix_cnt_d = pix_cnt_q;
      bias_d    = bias_q;
      case (state_q)
         IDLE: begin
            if (cfg_we) bias_d[cfg_addr] = cfg_bias;
            if (start) begin
               state_d   = RUN;
               oc_cnt_d  = '0;
               pix_cnt_d = '0;
            end
         end
         RUN: begin
            if (accept) begin
               if (oc_cnt_q == OC_W'(NUM_OC-1)) begin
                  oc_cnt_d  = '0;
                  pix_cnt_d = pix_cnt_q + PIX_W'(1);
               end else begin
                  oc_cnt_d = oc_cnt_q + OC_W'(1);
               end
               if (last_vec) state_d = DRAIN;
            end
         end
         DRAIN: if (vld_pipe_q == '0 && fifo_empty) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         oc_cnt_q   <= '0;
         pix_cnt_q  <= '0;
         bias_q     <= '0;
         vld_pipe_q <= '0;
         s1_sum_q   <= '0;
         s1_oc_q    <= '0;
         s1_pix_q   <= '0;
         s2_q       <= '0;
      end else begin
         state_q    <= state_d;
         oc_cnt_q   <= oc_cnt_d;
         pix_cnt_q  <= pix_cnt_d;
         bias_q     <= bias_d;
         vld_pipe_q <= vld_pipe_d;
         s1_sum_q   <= s1_sum_d;
         s1_oc_q    <= s1_oc_d;
         s1_pix_q   <= s1_pix_d;
         s2_q       <= s2_d;
      end
   end

   sync_fifo #(
      .WIDTH ($bits(res_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vld_pipe_q[2]),
      .din   (s2_q),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_ws_requant_scheduler.sv
module tb_ws_requant_scheduler;
   import ws_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                              rst, start, cfg_we, psum_valid;
   logic [OC_W-1:0]                   cfg_addr;
   logic [DATA_WIDTH-1:0]             cfg_bias;
   logic [SA_COL-1:0][PSUM_WIDTH-1:0] psum_i;
   logic                              psum_ready, out_valid, out_ready, busy, done;
   logic [DATA_WIDTH-1:0]             out_data;
   logic [OC_W-1:0]                   out_oc;
   logic [PIX_W-1:0]                  out_pix;
   logic                              rand_rdy, rdy_fix, rnd_bit;

   assign out_ready = rand_rdy ? rnd_bit : rdy_fix;

   ws_requant_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_bias(cfg_bias), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .psum_i(psum_i), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_oc(out_oc), .out_pix(out_pix), .busy(busy), .done(done)
   );

   typedef struct { int d; int oc; int pix; } rec_t;
   typedef struct { int p[SA_COL]; int d; int oc; int pix; } vec_t;

   int   n_tests = 0, n_fail = 0;
   rec_t exp_q[$], got_q[$];
   int   bias_m[NUM_OC];
   int   cur_p[SA_COL];
   int   k = 0, done_cnt = 0, pop_cnt = 0;
   vec_t tab[8];

   task automatic chk(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Reference: exact integer sum, floor division by 2^SHIFT, bias, clamp.
   function automatic int model(input int p[SA_COL], input int b);
      int s = 0, div, q, v, hi, lo;
      for (int i = 0; i < SA_COL; i++) s += p[i];
      div = 1 << SHIFT;
      q   = (s >= 0) ? s / div : -((-s + div - 1) / div);
      v   = q + b;
      hi  = (1 << (DATA_WIDTH-1)) - 1;
      lo  = -(1 << (DATA_WIDTH-1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   function automatic int randp();
      logic [PSUM_WIDTH-1:0] r;
      int p;
      r = PSUM_WIDTH'($urandom);
      p = int'($signed(r));
      if ($urandom % 2) p = p / 64;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_p(input int p[SA_COL]);
      cur_p = p;
      for (int i = 0; i < SA_COL; i++) psum_i[i] = p[i][PSUM_WIDTH-1:0];
   endtask

   task automatic rand_vec();
      int p[SA_COL];
      for (int i = 0; i < SA_COL; i++) p[i] = randp();
      drive_p(p);
   endtask

   // Channel is the inner loop: accept k carries (k % NUM_OC, k / NUM_OC).
   task automatic note_accept();
      rec_t e;
      e.oc  = k % NUM_OC;
      e.pix = k / NUM_OC;
      e.d   = model(cur_p, bias_m[e.oc]);
      exp_q.push_back(e);
      k++;
   endtask

   task automatic send(input int p[SA_COL]);
      int  n = 0;
      bit  acc;
      drive_p(p);
      psum_valid = 1'b1;
      do begin
         acc = psum_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      psum_valid = 1'b0;
      if (acc) note_accept();
      else chk("send_timeout", 0, 1);
   endtask

   task automatic cfg_write(input int a, input int v);
      cfg_we = 1'b1; cfg_addr = OC_W'(a); cfg_bias = DATA_WIDTH'(v);
      tick();
      cfg_we = 1'b0;
      bias_m[a] = v;
   endtask

   task automatic wait_pops(input int n);
      int c = 0;
      while (got_q.size() < n && c < 1000) begin tick(); c++; end
      chk("pops_reached", int'(got_q.size() >= n), 1);
   endtask

   task automatic setv(input int i, input int a, input int b, input int c, input int d,
                       input int oc, input int pix);
      tab[i].p[0] = a; tab[i].p[1] = b; tab[i].p[2] = c;
      tab[i].d = d; tab[i].oc = oc; tab[i].pix = pix;
   endtask

   initial forever begin
      @(posedge clk);
      #2;
      rnd_bit = 1'($urandom % 2);
   end

   // Output monitor: order/value scoreboard, hold-under-stall, done count.
   initial begin
      bit   hold_v = 1'b0;
      rec_t hold_r, r, e;
      forever begin
         @(negedge clk);
         if (rst) hold_v = 1'b0;
         else begin
            r.d = int'($signed(out_data)); r.oc = int'(out_oc); r.pix = int'(out_pix);
            if (hold_v) begin
               chk("hold_valid", int'(out_valid), 1);
               chk("hold_data", r.d, hold_r.d);
               chk("hold_oc", r.oc, hold_r.oc);
               chk("hold_pix", r.pix, hold_r.pix);
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
               got_q.push_back(r);
               pop_cnt++;
               if (exp_q.size() == 0) chk("unexpected_pop", 0, 1);
               else begin
                  e = exp_q.pop_front();
                  chk("data", r.d, e.d);
                  chk("oc", r.oc, e.oc);
                  chk("pix", r.pix, e.pix);
               end
            end
            hold_v = out_valid && !out_ready;
            hold_r = r;
         end
      end
   end

   initial begin
      int acc_n, c;
      bit acc;
      int z[SA_COL];
      rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0;
      psum_valid = 1'b0; psum_i = '0; rand_rdy = 1'b0; rdy_fix = 1'b1; rnd_bit = 1'b0;
      for (int i = 0; i < NUM_OC; i++) bias_m[i] = 0;
      repeat (3) tick();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_psum_ready", int'(psum_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_tags", int'(out_oc) + int'(out_pix), 0);
      rst = 1'b0;
      tick();

      cfg_write(0, 0); cfg_write(1, 5); cfg_write(2, 127); cfg_write(3, -128);

      setv(0, -1, 0, 0, -1, 0, 0);
      setv(1, 128, 256, -128, 7, 1, 0);
      setv(2, 131072, 0, 0, 127, 2, 0);
      setv(3, -131072, 0, 0, -128, 3, 0);
      setv(4, 100, -300, 50, -2, 0, 1);
      setv(5, 262143, 262143, 262143, 127, 1, 1);
      setv(6, -262144, -262144, -262144, -128, 2, 1);
      setv(7, 12800, 0, 0, -28, 3, 1);

      start = 1'b1; tick(); start = 1'b0; k = 0;
      chk("run_busy", int'(busy), 1);

      // First-result latency: accept edge, then out_valid in the third cycle after.
      send(tab[0].p);
      chk("lat_t1", int'(out_valid), 0);
      tick();
      chk("lat_t2", int'(out_valid), 0);
      tick();
      chk("lat_t3", int'(out_valid), 1);
      for (int i = 1; i < 8; i++) send(tab[i].p);
      wait_pops(8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         chk("tab_data", got_q[i].d, tab[i].d);
         chk("tab_oc", got_q[i].oc, tab[i].oc);
         chk("tab_pix", got_q[i].pix, tab[i].pix);
      end

      // Backpressure: with the output stalled only FIFO_DEPTH vectors get in.
      rdy_fix = 1'b0;
      rand_vec();
      psum_valid = 1'b1;
      acc_n = 0;
      repeat (12) begin
         acc = psum_ready;
         tick();
         if (acc) begin note_accept(); acc_n++; rand_vec(); end
      end
      psum_valid = 1'b0;
      chk("bp_accepts", acc_n, FIFO_DEPTH);
      chk("bp_ready_low", int'(psum_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      rdy_fix = 1'b1;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
         chk("bp_stream", int'(out_valid), 1);
         tick();
      end
      chk("bp_drained", int'(out_valid), 0);

      // Writes and start during RUN must be ignored; bias_m stays as is.
      cfg_we = 1'b1; cfg_addr = '0; cfg_bias = 8'd100; start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0;

      rand_rdy = 1'b1;
      while (k < NUM_OC*NUM_PIX) begin
         if ($urandom % 4 == 0) tick();
         rand_vec();
         send(cur_p);
      end
      psum_valid = 1'b1;
      repeat (3) begin
         chk("drain_ready", int'(psum_ready), 0);
         tick();
      end
      psum_valid = 1'b0;
      c = 0;
      while (!done && c < 1000) begin tick(); c++; end
      chk("done_seen", int'(done), 1);
      chk("done_busy", int'(busy), 1);
      chk("pop_total", pop_cnt, NUM_OC*NUM_PIX);
      chk("exp_empty", exp_q.size(), 0);
      tick();
      chk("done_one_cycle", int'(done), 0);
      chk("busy_fell", int'(busy), 0);
      chk("done_count", done_cnt, 1);
      rand_rdy = 1'b0; rdy_fix = 1'b1;

      // start + cfg_we in the same IDLE cycle: the new bias applies to this pass.
      cfg_we = 1'b1; cfg_addr = OC_W'(2); cfg_bias = DATA_WIDTH'(-50); start = 1'b1;
      tick();
      cfg_we = 1'b0; start = 1'b0; bias_m[2] = -50; k = 0;
      z[0] = 0;    z[1] = 0; z[2] = 0; send(z);
      z[0] = 256;  send(z);
      z[0] = 1280; send(z);
      wait_pops(NUM_OC*NUM_PIX + 3);
      if (got_q.size() >= NUM_OC*NUM_PIX + 3) begin
         chk("stcfg_bias0", got_q[NUM_OC*NUM_PIX].d, 0);
         chk("stcfg_bias1", got_q[NUM_OC*NUM_PIX+1].d, 7);
         chk("stcfg_bias2", got_q[NUM_OC*NUM_PIX+2].d, -40);
      end

      // Reset mid-RUN with two results queued: pass abandoned, no done pulse.
      rdy_fix = 1'b0;
      rand_vec(); send(cur_p);
      rand_vec(); send(cur_p);
      repeat (4) tick();
      chk("rst_pre_valid", int'(out_valid), 1);
      rst = 1'b1;
      exp_q.delete();
      tick();
      chk("mrst_out_valid", int'(out_valid), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_psum_ready", int'(psum_ready), 0);
      chk("mrst_done", int'(done), 0);
      rst = 1'b0; rdy_fix = 1'b1;
      repeat (5) tick();
      chk("mrst_no_done", done_cnt, 1);
      chk("mrst_idle_valid", int'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
